// File: rtl/adc_pkg.sv
// Shared definitions for the ADC burst sequencer: FSM state encoding.
// The encoding makes run decode as state[1] & ~state[0].
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GAP  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/adc_seq_timer.sv
// Loadable down-counter with a zero flag, used for the inter-burst gap and the sample timeout.
module adc_seq_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_burst_sequencer.sv
// ADC burst sequencer: IDLE -> RUN (-> GAP -> RUN)* -> DONE, with abort priority.
// Optional sample timeout is compiled in with ADC_SEQ_TIMEOUT_EN.
module adc_burst_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned BURST_W     = 16,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   samples_per_burst,
    input  logic [BURST_W-1:0] burst_count,
    input  logic [CNT_W-1:0]   gap_cycles,
    input  logic               sample_done,
    output logic               run,
    output logic               last,
    output logic               seq_done,
    output logic               active,
    output logic [BURST_W-1:0] burst_idx,
    output logic               timeout_err
);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   spb_q, spb_d, gap_q, gap_d, cnt_q, cnt_d;
    logic [BURST_W-1:0] bc_q, bc_d, bidx_q, bidx_d;
    logic               run_q, active_q, done_q;
    logic               last_c, accept_c, gap_load, gap_zero, tmo_hit;

    adc_seq_timer #(.W(CNT_W)) u_gap_timer (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .load_i     (gap_load),
        .load_val_i (gap_q - 1'b1),
        .en_i       (state_q == GAP),
        .zero_o     (gap_zero)
    );

`ifdef ADC_SEQ_TIMEOUT_EN
    logic tmo_zero, tmo_err_q, tmo_err_d;

    // Reloaded on RUN entry and on every accepted sample, so it measures silence in RUN.
    adc_seq_timer #(.W(CNT_W)) u_tmo_timer (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .load_i     ((state_d == RUN) && ((state_q != RUN) || sample_done)),
        .load_val_i (CNT_W'(TIMEOUT_CYC - 1)),
        .en_i       (state_q == RUN),
        .zero_o     (tmo_zero)
    );

    assign tmo_hit = (state_q == RUN) && !sample_done && tmo_zero;

    always_comb begin
        tmo_err_d = tmo_err_q;
        if (!abort && tmo_hit) begin
            tmo_err_d = 1'b1;
        end else if (accept_c) begin
            tmo_err_d = 1'b0;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        spb_d    = spb_q;
        bc_d     = bc_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        last_c   = 1'b0;
        accept_c = 1'b0;
        gap_load = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            bidx_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (samples_per_burst != '0)) begin
                        accept_c = 1'b1;
                        spb_d    = samples_per_burst;
                        bc_d     = burst_count;
                        gap_d    = gap_cycles;
                        cnt_d    = '0;
                        bidx_d   = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (sample_done) begin
                        if (cnt_q + 1'b1 == spb_q) begin
                            last_c = 1'b1;
                            cnt_d  = '0;
                            bidx_d = bidx_q + 1'b1;
                            if ((bc_q != '0) && (bidx_d == bc_q)) begin
                                state_d = DONE;
                            end else if (gap_q != '0) begin
                                state_d  = GAP;
                                gap_load = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        bidx_d  = '0;
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            spb_q    <= '0;
            bc_q     <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            bidx_q   <= '0;
            run_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            spb_q    <= spb_d;
            bc_q     <= bc_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            run_q    <= (state_d == RUN);
            active_q <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_err_q <= tmo_err_d;
`endif
        end
    end

    assign run       = run_q;
    assign active    = active_q;
    assign last      = last_c;
    assign seq_done  = done_q & ~abort;
    assign burst_idx = bidx_q;

endmodule
